// File: rtl/axo32_debug_memseq.sv
// Debug memory sequencer: turns debug commands into single-byte accesses on the core bus override port.
// Optional build macro AXO32_DEBUG_AUTOINC_EN: post-increment mem_addr after each successful READ/WRITE.
module axo32_debug_memseq #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   input  logic        override_en,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 8;

   localparam logic [1:0] OP_SETADDR = 2'b00;
   localparam logic [1:0] OP_READ    = 2'b01;
   localparam logic [1:0] OP_WRITE   = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_e;

   state_e state_q, state_d;

   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_re_q,    mem_re_d;
   logic              mem_we_q,    mem_we_d;
   logic [CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;

   logic accept_c;
   logic mem_op_c;
   logic abort_c;
   logic timeout_c;

   assign accept_c  = (state_q == IDLE) && cmd_valid;
   assign mem_op_c  = (cmd_op == OP_READ) || (cmd_op == OP_WRITE);
   assign abort_c   = !override_en;
   // Terminal count: this cycle's increment would reach TIMEOUT.
   assign timeout_c = !mem_ready && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c) state_d = (mem_op_c && override_en) ? ACCESS : RESP;
         end
         ACCESS: begin
            if (abort_c || mem_ready || timeout_c) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_re_d    = mem_re_q;
      mem_we_d    = mem_we_q;
      wait_cnt_d  = wait_cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               if (cmd_op == OP_SETADDR) mem_addr_d = cmd_wdata;
               if (mem_op_c) begin
                  if (override_en) begin
                     mem_re_d   = (cmd_op == OP_READ);
                     mem_we_d   = (cmd_op == OP_WRITE);
                     wait_cnt_d = '0;
                     if (cmd_op == OP_WRITE) mem_wdata_d = cmd_wdata[DATA_W-1:0];
                  end else begin
                     rsp_err_d = 1'b1;
                  end
               end
            end
         end
         ACCESS: begin
            if (abort_c || timeout_c) begin
               mem_re_d  = 1'b0;
               mem_we_d  = 1'b0;
               rsp_err_d = 1'b1;
            end else if (mem_ready) begin
               mem_re_d  = 1'b0;
               mem_we_d  = 1'b0;
               rsp_err_d = 1'b0;
               if (mem_re_q) rsp_rdata_d = mem_rdata;
`ifdef AXO32_DEBUG_AUTOINC_EN
               mem_addr_d = mem_addr_q + ADDR_W'(1);
`endif
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: begin
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;

endmodule

// File: doc/axo32_debug_memseq.md
AXO32_DEBUG_MEMSEQ -- requirements
Module: axo32_debug_memseq

Interface
REQ-001 Parameter TIMEOUT, default 255, bus-access cycle limit (range 1..255) before an error response.
REQ-002 clock  input  1  ungated core clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 cmd_valid  input  1  debug command offered.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_op  input  2  command: 00 SETADDR, 01 READ, 10 WRITE, 11 NOP.
REQ-007 cmd_wdata  input  32  SETADDR address, or WRITE data in bits [7:0].
REQ-008 rsp_valid  output  1  response available.
REQ-009 rsp_ready  input  1  response consumer ready.
REQ-010 rsp_rdata  output  8  READ data; 0 for all other ops and for errors.
REQ-011 rsp_err  output  1  command failed (timeout, no override, or abort).
REQ-012 override_en  input  1  debug bus override granted (debug selected and core halted).
REQ-013 mem_addr  output  32  byte address driven to the override bus.
REQ-014 mem_wdata  output  8  write byte.
REQ-015 mem_re  output  1  read strobe.
REQ-016 mem_we  output  1  write strobe.
REQ-017 mem_rdata  input  8  read byte from the bus.
REQ-018 mem_ready  input  1  bus completes the current access.

Function
REQ-019 The block SHALL be a three-state FSM: IDLE, ACCESS, RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle with cmd_valid and cmd_ready both high.
REQ-021 SETADDR and NOP SHALL go IDLE->RESP. SETADDR SHALL load mem_addr from cmd_wdata. Both SHALL respond with rsp_err=0 and rsp_rdata=0.
REQ-022 READ or WRITE accepted with override_en=0 SHALL go IDLE->RESP with rsp_err=1 and no bus strobe.
REQ-023 READ or WRITE accepted with override_en=1 SHALL go IDLE->ACCESS. WRITE SHALL latch cmd_wdata[7:0] into mem_wdata.
REQ-024 The strobes mem_re/mem_we SHALL be registered. The strobe matching the op SHALL be high from the first ACCESS cycle through the cycle mem_ready is sampled high. The strobes SHALL never be high together and SHALL be low outside ACCESS.
REQ-025 When mem_ready is high in ACCESS, READ SHALL capture mem_rdata into rsp_rdata. The FSM SHALL go to RESP with rsp_err=0; rsp_valid SHALL rise the next cycle.
REQ-026 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without mem_ready.
REQ-027 When the wait counter reaches TIMEOUT with mem_ready low, the FSM SHALL drop the strobe and go to RESP with rsp_err=1.
REQ-028 If override_en falls during ACCESS, the strobe SHALL drop that cycle's next edge and the FSM SHALL go to RESP with rsp_err=1. This abort SHALL take priority over a simultaneous mem_ready.
REQ-029 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready is high, then return to IDLE. A new command SHALL be accepted no earlier than the following cycle.
REQ-030 Minimum READ/WRITE latency SHALL be 3 cycles: accept (N), strobe with mem_ready (N+1), rsp_valid (N+2).

Reset
REQ-031 While reset_n=0 on a clock edge, the block SHALL:
- enter IDLE;
- drive mem_addr=0, mem_wdata=0, mem_re=0, mem_we=0;
- drive rsp_valid=0, rsp_rdata=0, rsp_err=0;
- clear the wait counter.
REQ-032 Reset mid-ACCESS or mid-RESP SHALL abandon the operation with no response. The strobes SHALL be low on the first cycle after the reset edge.

Configuration
REQ-033 Macro AXO32_DEBUG_AUTOINC_EN, when defined, SHALL make mem_addr increment by 1 after each successful (rsp_err=0) READ/WRITE, wrapping 0xFFFFFFFF->0x00000000.
REQ-034 Without AXO32_DEBUG_AUTOINC_EN, mem_addr SHALL change only on SETADDR and reset. No increment logic SHALL be present.

Verification
REQ-035 SETADDR 0x00001000, then WRITE 0xA5 with override_en=1 and mem_ready=1 on the first strobe cycle -> mem_we pulses 1 cycle with mem_addr=0x1000 and mem_wdata=0xA5; rsp_err=0; rsp_valid at cycle N+2.
REQ-036 READ with mem_ready delayed 4 cycles and mem_rdata=0x3C -> mem_re high for 5 cycles; rsp_rdata=0x3C, rsp_err=0. With AUTOINC_EN, the next READ drives mem_addr=0x1001.
REQ-037 TIMEOUT=8, READ with mem_ready held low -> mem_re drops after 8 cycles; rsp_err=1, rsp_rdata=0; mem_addr unchanged.
REQ-038 WRITE with override_en=0 -> no strobe; rsp_err=1 on the next cycle. Then override_en falling on ACCESS cycle 2 -> strobe drops; rsp_err=1.
REQ-039 With AUTOINC_EN, SETADDR 0xFFFFFFFF then successful READ -> mem_addr=0x00000000. Holding rsp_ready=0 for 3 cycles keeps the response stable and cmd_ready=0.
REQ-040 reset_n=0 during ACCESS -> strobes low and rsp_valid=0 next cycle; FSM in IDLE with cmd_ready=1 after reset_n=1.
